// File: rtl/sample_dma_pkg.sv
// Shared definitions for the sample FIFO to SDRAM drain: register offsets,
// CTRL bit positions and FSM state encodings.
package sample_dma_pkg;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_BASE  = 2'd1;
   localparam logic [1:0] REG_LIMIT = 2'd2;
   localparam logic [1:0] REG_WPTR  = 2'd3;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_CIRCULAR = 1;
   localparam int CTRL_CLEAR    = 2;
   localparam int CTRL_BUSY     = 8;
   localparam int CTRL_FULL     = 9;
   localparam int CTRL_WRAP     = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_LATCH = 3'd2,
      ST_WRITE = 3'd3,
      ST_FULL  = 3'd4
   } dma_state_t;

endpackage

// File: rtl/sample_dma.sv
// Drains 16-bit sample words from the sample FIFO into an SDRAM ring or
// one-shot buffer, one word per POP/LATCH/WRITE pass.
module sample_dma
   import sample_dma_pkg::*;
#(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic          clk_48,
   input  logic          irst,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   input  logic [DW-1:0] fifo_data,
   output logic [AW-1:0] awaddr,
   output logic [DW-1:0] wdata,
   output logic          wvalid,
   input  logic          wready,
   input  logic [1:0]    reg_addr,
   input  logic [31:0]   reg_wdata,
   input  logic          reg_wr,
   output logic [31:0]   reg_rdata,
   output logic          irq_full
);

   dma_state_t    state;
   logic          enable;
   logic          circular;
   logic          full_flag;
   logic          wrap_flag;
   logic [AW-1:0] base;
   logic [AW-1:0] limit;
   logic [AW-1:0] wptr;
   logic [AW-1:0] wptr_inc;
   logic          cfg_open;
   logic          ctrl_wr;
   logic          clear_req;
   logic          unused_wdata_bits;

   assign wptr_inc  = wptr + AW'(1);
   assign cfg_open  = !enable && (state == ST_IDLE);
   assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
   assign clear_req = ctrl_wr && reg_wdata[CTRL_CLEAR];
   assign irq_full  = full_flag | wrap_flag;
   assign unused_wdata_bits = ^reg_wdata[31:AW];

   // Register file, pointer unit and FSM share one process so that a beat
   // setting WRAP/FULL overrides a same-cycle CTRL clear (later assignment wins).
   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         state     <= ST_IDLE;
         enable    <= 1'b0;
         circular  <= 1'b0;
         full_flag <= 1'b0;
         wrap_flag <= 1'b0;
         base      <= '0;
         limit     <= '0;
         wptr      <= '0;
         awaddr    <= '0;
         wdata     <= '0;
         wvalid    <= 1'b0;
         fifo_rd   <= 1'b0;
      end else begin
         fifo_rd <= 1'b0;

         if (ctrl_wr) begin
            enable   <= reg_wdata[CTRL_ENABLE];
            circular <= reg_wdata[CTRL_CIRCULAR];
            if (reg_wdata[CTRL_CLEAR]) begin
               wrap_flag <= 1'b0;
               full_flag <= 1'b0;
            end
         end

         if (reg_wr && cfg_open) begin
            case (reg_addr)
               REG_BASE:  base  <= reg_wdata[AW-1:0];
               REG_LIMIT: limit <= reg_wdata[AW-1:0];
               REG_WPTR:  wptr  <= reg_wdata[AW-1:0];
               default:   ;
            endcase
         end

         case (state)
            ST_IDLE: begin
               if (enable && !full_flag && !fifo_empty) begin
                  fifo_rd <= 1'b1;
                  state   <= ST_POP;
               end
            end
            ST_POP: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               wdata  <= fifo_data;
               awaddr <= wptr;
               wvalid <= 1'b1;
               state  <= ST_WRITE;
            end
            ST_WRITE: begin
               if (wready) begin
                  wvalid <= 1'b0;
                  if (wptr_inc != limit) begin
                     wptr  <= wptr_inc;
                     state <= ST_IDLE;
                  end else if (circular) begin
                     wptr      <= base;
                     wrap_flag <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     wptr      <= limit;
                     full_flag <= 1'b1;
                     state     <= ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (clear_req) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read mux is combinational on reg_addr so the CPU sees it in the same cycle.
   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         REG_CTRL: begin
            reg_rdata[CTRL_ENABLE]   = enable;
            reg_rdata[CTRL_CIRCULAR] = circular;
            reg_rdata[CTRL_BUSY]     = (state != ST_IDLE);
            reg_rdata[CTRL_FULL]     = full_flag;
            reg_rdata[CTRL_WRAP]     = wrap_flag;
         end
         REG_BASE:  reg_rdata[AW-1:0] = base;
         REG_LIMIT: reg_rdata[AW-1:0] = limit;
         REG_WPTR:  reg_rdata[AW-1:0] = wptr;
         default:   reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_sample_dma.sv
// Directed bench for sample_dma: a FIFO model feeds words, expected SDRAM
// beats go into a scoreboard queue and a negedge monitor checks each beat.
module tb_sample_dma;

   localparam int AW = 24;
   localparam int DW = 16;

   logic          clk_48 = 1'b0;
   logic          irst;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [DW-1:0] fifo_data;
   logic [AW-1:0] awaddr;
   logic [DW-1:0] wdata;
   logic          wvalid;
   logic          wready;
   logic [1:0]    reg_addr;
   logic [31:0]   reg_wdata;
   logic          reg_wr;
   logic [31:0]   reg_rdata;
   logic          irq_full;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] src_words[$];
   int            wr_idx = 0;
   int            rd_idx = 0;

   logic [AW+DW-1:0] exp_q[$];
   int               exp_rd = 0;

   always #10 clk_48 = ~clk_48;

   sample_dma #(.AW(AW), .DW(DW)) dut (
      .clk_48     (clk_48),
      .irst       (irst),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .awaddr     (awaddr),
      .wdata      (wdata),
      .wvalid     (wvalid),
      .wready     (wready),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr     (reg_wr),
      .reg_rdata  (reg_rdata),
      .irq_full   (irq_full)
   );

   assign fifo_empty = (rd_idx == wr_idx);

   // FIFO read side: data appears the cycle after fifo_rd.
   always @(posedge clk_48) begin
      if (fifo_rd) begin
         if (rd_idx < wr_idx) begin
            fifo_data <= src_words[rd_idx];
         end else begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL fifo_underflow: fifo_rd=1 with rd_idx=%0d wr_idx=%0d, required no read", rd_idx, wr_idx);
         end
         rd_idx <= rd_idx + 1;
      end
   end

   // Scoreboard monitor: one comparison per completed beat.
   always @(negedge clk_48) begin
      if (!irst && wvalid && wready) begin
         n_vec++;
         if (exp_rd >= exp_q.size()) begin
            n_err++;
            $display("[TB] FAIL unexpected_beat: addr=%h data=%h, required no beat", awaddr, wdata);
         end else begin
            if ({awaddr, wdata} !== exp_q[exp_rd]) begin
               n_err++;
               $display("[TB] FAIL beat%0d: addr=%h data=%h, required addr=%h data=%h",
                        exp_rd, awaddr, wdata, exp_q[exp_rd][AW+DW-1:DW], exp_q[exp_rd][DW-1:0]);
            end
            exp_rd++;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_48);
      #1;
   endtask

   task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
      reg_addr  = addr;
      reg_wdata = data;
      reg_wr    = 1'b1;
      @(posedge clk_48);
      #1;
      reg_wr = 1'b0;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      n_vec++;
      if (actual !== required) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
      end
   endtask

   task automatic check_reg(input string name, input logic [1:0] addr, input logic [31:0] required);
      reg_addr = addr;
      #1;
      check_output(name, reg_rdata, required);
   endtask

   task automatic apply_stimulus(input logic [DW-1:0] word, input logic expect_beat, input logic [AW-1:0] addr);
      src_words.push_back(word);
      wr_idx = wr_idx + 1;
      if (expect_beat) exp_q.push_back({addr, word});
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 300;
      while (exp_rd < exp_q.size() && budget > 0) begin
         @(posedge clk_48);
         budget--;
      end
      #1;
      if (budget == 0) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL %s_timeout: %0d beats seen, required %0d", name, exp_rd, exp_q.size());
      end
      wait_cycles(3);
   endtask

   initial begin
      logic [AW-1:0] held_addr;
      logic [DW-1:0] held_data;
      logic          stable;
      int            budget;

      irst      = 1'b1;
      wready    = 1'b1;
      reg_addr  = 2'd0;
      reg_wdata = '0;
      reg_wr    = 1'b0;
      wait_cycles(3);
      irst = 1'b0;
      wait_cycles(1);

      $display("[TB] reset state");
      check_reg("rst_ctrl",  2'd0, 32'h0);
      check_reg("rst_base",  2'd1, 32'h0);
      check_reg("rst_limit", 2'd2, 32'h0);
      check_reg("rst_wptr",  2'd3, 32'h0);
      check_output("rst_fifo_rd", {31'd0, fifo_rd}, 32'h0);
      check_output("rst_wvalid", {31'd0, wvalid}, 32'h0);
      check_output("rst_irq", {31'd0, irq_full}, 32'h0);

      $display("[TB] three words into linear buffer");
      reg_write(2'd1, 32'h100);
      reg_write(2'd2, 32'h104);
      reg_write(2'd3, 32'h100);
      reg_write(2'd0, 32'h1);
      apply_stimulus(16'h00A1, 1'b1, 24'h100);
      apply_stimulus(16'h00A2, 1'b1, 24'h101);
      apply_stimulus(16'h00A3, 1'b1, 24'h102);
      drain("linear");
      check_reg("lin_wptr", 2'd3, 32'h103);
      check_reg("lin_ctrl", 2'd0, 32'h1);

      $display("[TB] one-shot fill");
      reg_write(2'd0, 32'h0);
      reg_write(2'd3, 32'h100);
      reg_write(2'd0, 32'h1);
      apply_stimulus(16'h00B1, 1'b1, 24'h100);
      apply_stimulus(16'h00B2, 1'b1, 24'h101);
      apply_stimulus(16'h00B3, 1'b1, 24'h102);
      apply_stimulus(16'h00B4, 1'b1, 24'h103);
      apply_stimulus(16'h00B5, 1'b0, 24'h0);
      drain("oneshot");
      wait_cycles(5);
      check_reg("full_ctrl", 2'd0, 32'h301);
      check_reg("full_wptr", 2'd3, 32'h104);
      check_output("full_irq", {31'd0, irq_full}, 32'h1);
      check_output("full_fifo_left", wr_idx - rd_idx, 32'd1);
      reg_write(2'd0, 32'h4);
      check_reg("clr_ctrl", 2'd0, 32'h0);
      check_output("clr_irq", {31'd0, irq_full}, 32'h0);
      reg_write(2'd3, 32'h100);
      exp_q.push_back({24'h100, 16'h00B5});
      reg_write(2'd0, 32'h1);
      drain("refill");
      check_reg("refill_wptr", 2'd3, 32'h101);

      $display("[TB] circular wrap");
      reg_write(2'd0, 32'h0);
      reg_write(2'd3, 32'h100);
      reg_write(2'd0, 32'h3);
      apply_stimulus(16'h00C1, 1'b1, 24'h100);
      apply_stimulus(16'h00C2, 1'b1, 24'h101);
      apply_stimulus(16'h00C3, 1'b1, 24'h102);
      apply_stimulus(16'h00C4, 1'b1, 24'h103);
      apply_stimulus(16'h00C5, 1'b1, 24'h100);
      apply_stimulus(16'h00C6, 1'b1, 24'h101);
      drain("circular");
      check_reg("wrap_ctrl", 2'd0, 32'h403);
      check_reg("wrap_wptr", 2'd3, 32'h102);
      check_output("wrap_irq", {31'd0, irq_full}, 32'h1);
      reg_write(2'd0, 32'h4);
      check_reg("wrap_clr_ctrl", 2'd0, 32'h0);

      $display("[TB] wready stall");
      reg_write(2'd3, 32'h100);
      reg_write(2'd0, 32'h1);
      wready = 1'b0;
      apply_stimulus(16'h00D1, 1'b1, 24'h100);
      budget = 50;
      while (!wvalid && budget > 0) begin
         wait_cycles(1);
         budget--;
      end
      check_output("stall_wvalid_seen", {31'd0, wvalid}, 32'h1);
      held_addr = awaddr;
      held_data = wdata;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_cycles(1);
         if (!wvalid || awaddr !== held_addr || wdata !== held_data) stable = 1'b0;
      end
      check_output("stall_stable", {31'd0, stable}, 32'h1);
      check_output("stall_no_beat", exp_rd, exp_q.size() - 1);
      wready = 1'b1;
      drain("stall");
      check_reg("stall_wptr", 2'd3, 32'h101);

      $display("[TB] enable cleared mid-transfer");
      apply_stimulus(16'h00E1, 1'b1, 24'h101);
      apply_stimulus(16'h00E2, 1'b0, 24'h0);
      budget = 50;
      while (!fifo_rd && budget > 0) begin
         wait_cycles(1);
         budget--;
      end
      check_output("mid_fifo_rd_seen", {31'd0, fifo_rd}, 32'h1);
      wait_cycles(1);
      reg_write(2'd0, 32'h0);
      reg_write(2'd1, 32'h200);
      drain("midclear");
      wait_cycles(20);
      check_output("mid_fifo_left", wr_idx - rd_idx, 32'd1);
      check_reg("mid_base", 2'd1, 32'h100);
      check_reg("mid_ctrl", 2'd0, 32'h0);
      check_reg("mid_wptr", 2'd3, 32'h102);
      check_output("beats_total", exp_rd, exp_q.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
